apb4_to_reg_pipe: RTL and testbench
===================================

# apb4_to_reg_pipe

Registered APB4-to-register-interface bridge with parametrised widths, byte strobes, privilege filtering and a request timeout. It sits between an APB4 peripheral bus and register-file endpoints. A three-state FSM fully registers both the forward request and the backward response, so no combinational path runs from the register endpoint to the APB bus. Use it wherever timing closure or hung endpoints make the plain feedthrough bridge unsuitable.

## Interface
- AddrWidth, 32: width of paddr_i / reg_addr_o.
- DataWidth, 32: data width; multiple of 8.
- StrbWidth, DataWidth/8: derived, do not override.
- TimeoutCycles, 0: REQ cycles without reg_ready_i before abort; 0 disables the timeout.
- PrivOnly, 1'b0: when 1, accesses with pprot_i[0]==0 are rejected with an error.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- psel_i, penable_i, pwrite_i  in  1 each  APB4 control.
- paddr_i  in  AddrWidth  APB address.
- pprot_i  in  3  APB protection; only bit 0 (privileged) is used.
- pwdata_i  in  DataWidth  write data.
- pstrb_i  in  StrbWidth  write byte strobes.
- prdata_o  out  DataWidth  read data.
- pready_o  out  1  transfer complete.
- pslverr_o  out  1  transfer error.
- reg_addr_o  out  AddrWidth  register request address.
- reg_write_o  out  1  register request is a write.
- reg_wdata_o  out  DataWidth  register write data.
- reg_wstrb_o  out  StrbWidth  register byte strobes.
- reg_valid_o  out  1  register request valid.
- reg_rdata_i  in  DataWidth  register read data.
- reg_error_i  in  1  register error.
- reg_ready_i  in  1  register request accepted / completed.
- timeout_o  out  1  one-cycle pulse when a request is aborted by the timeout.

## Operation
- FSM states: IDLE, REQ, RESP. Reset state is IDLE.
- IDLE:
  - psel_i & !penable_i (setup phase) latches paddr_i, pwrite_i and pwdata_i.
  - Strobe latch: pstrb_i for writes; all-zero for reads.
  - Clears the timeout counter.
  - Next state: REQ. If PrivOnly and !pprot_i[0], next state is RESP with the error flag set and read data 0; no register request is issued.
- REQ:
  - reg_valid_o=1; reg_addr/write/wdata/wstrb_o are driven from the latches and stay stable.
  - reg_ready_i=1: latch reg_rdata_i (reads; 0 for writes) and reg_error_i, go to RESP.
  - Otherwise the counter increments. With TimeoutCycles>0 and counter==TimeoutCycles-1 (and no ready): latch read data 0, error 1, pulse timeout_o, go to RESP.
  - If reg_ready_i and the timeout fall in the same cycle, ready wins: normal completion, no timeout_o.
- RESP:
  - pready_o=1, prdata_o=latched data, pslverr_o=latched error; next state IDLE unconditionally.
  - Outside RESP: pready_o=0, pslverr_o=0, prdata_o=0.
- Counter width is $clog2(TimeoutCycles+1), minimum 1; it saturates and never wraps.
- Protocol violation (psel_i dropped while in REQ or RESP): the FSM completes its sequence regardless; the request is not cancelled.
- psel_i & penable_i while in IDLE (no preceding setup phase) is ignored.
- Reset mid-operation: immediate return to IDLE. All outputs go to their reset values; an in-flight register request is dropped.

## Timing
- Reset values: every output is 0, including reg_addr_o, reg_wdata_o, reg_wstrb_o and timeout_o.
- All outputs are registered or decoded from FSM state only. There is no combinational path from any input to any output.
- Cycle numbering: setup phase at cycle T. REQ at T+1. With reg_ready_i at T+1, RESP (pready_o=1) is at T+2.
- Minimum transfer length is 3 cycles (setup plus 2 access), i.e. one wait state.
- Each REQ cycle without ready adds one cycle.
- With a timeout, pready_o rises at T+TimeoutCycles+1.
- A privilege reject gives pready_o at T+1 with pslverr_o=1.
- A back-to-back setup phase is accepted in the cycle after RESP (IDLE).

## Test plan
- Write: paddr 0x40, pwdata 0xDEADBEEF, pstrb 4'b0011; endpoint ready at first REQ cycle.
  - Expect reg_wstrb_o=0011 and reg_valid_o high for exactly 1 cycle.
  - Expect pready_o at T+2 with pslverr_o=0.
- Read: endpoint holds reg_ready_i low 3 cycles, then returns 0x12345678 with ready.
  - Expect prdata_o=0x12345678 and pready_o at T+5.
  - Expect reg_wstrb_o=0 throughout.
- TimeoutCycles=4, endpoint never ready.
  - Expect reg_valid_o high 4 cycles, then timeout_o pulse.
  - Expect pready_o=1, pslverr_o=1, prdata_o=0 at T+5.
- TimeoutCycles=4, reg_ready_i with reg_error_i=1 on the 4th REQ cycle.
  - Expect pslverr_o=1 and no timeout_o pulse.
- PrivOnly=1, pprot_i=3'b000 write.
  - Expect reg_valid_o never asserted.
  - Expect pready_o=1, pslverr_o=1 at T+1.
  - A follow-up access with pprot_i=3'b001 completes normally.
- Assert rst_ni low during REQ.
  - Expect reg_valid_o and all outputs 0 immediately.
  - After release, a fresh read completes in 3 cycles.

Source files
------------

// File: rtl/apb4_to_reg_pipe.sv
// Registered APB4-to-register-interface bridge with byte strobes, privilege filtering
// and a request timeout. Both the request and the response paths are fully registered.
module apb4_to_reg_pipe #(
   parameter int unsigned AddrWidth     = 32,
   parameter int unsigned DataWidth     = 32,
   parameter int unsigned StrbWidth     = DataWidth / 8,
   parameter int unsigned TimeoutCycles = 0,
   parameter bit          PrivOnly      = 1'b0
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 psel_i,
   input  logic                 penable_i,
   input  logic                 pwrite_i,
   input  logic [AddrWidth-1:0] paddr_i,
   input  logic [2:0]           pprot_i,
   input  logic [DataWidth-1:0] pwdata_i,
   input  logic [StrbWidth-1:0] pstrb_i,
   output logic [DataWidth-1:0] prdata_o,
   output logic                 pready_o,
   output logic                 pslverr_o,
   output logic [AddrWidth-1:0] reg_addr_o,
   output logic                 reg_write_o,
   output logic [DataWidth-1:0] reg_wdata_o,
   output logic [StrbWidth-1:0] reg_wstrb_o,
   output logic                 reg_valid_o,
   input  logic [DataWidth-1:0] reg_rdata_i,
   input  logic                 reg_error_i,
   input  logic                 reg_ready_i,
   output logic                 timeout_o
);

   localparam bit          TimeoutEn = (TimeoutCycles != 0);
   localparam int unsigned CntWidth  = TimeoutEn ? (($clog2(TimeoutCycles + 1) > 0) ?
                                                    $clog2(TimeoutCycles + 1) : 1) : 1;
   localparam logic [CntWidth-1:0] CntLast = CntWidth'(TimeoutCycles - 1);
   localparam logic [CntWidth-1:0] CntMax  = {CntWidth{1'b1}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic [CntWidth-1:0]   cnt_q, cnt_d;
   logic [AddrWidth-1:0]  addr_q;
   logic                  write_q;
   logic [DataWidth-1:0]  wdata_q;
   logic [StrbWidth-1:0]  wstrb_q;
   logic [DataWidth-1:0]  rdata_q, rdata_d;
   logic                  err_q, err_d;
   logic                  timeout_q, timeout_d;
   logic                  latch_req;
   logic                  load_resp;
   logic                  unused_prot;

   // Only the privileged bit of pprot is meaningful here.
   assign unused_prot = ^pprot_i[2:1];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      latch_req = 1'b0;
      load_resp = 1'b0;
      rdata_d   = '0;
      err_d     = 1'b0;
      timeout_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (psel_i && !penable_i) begin
               latch_req = 1'b1;
               if (PrivOnly && !pprot_i[0]) begin
                  // Unprivileged access: answer with an error without touching the endpoint.
                  load_resp = 1'b1;
                  err_d     = 1'b1;
                  state_d   = RESP;
               end else begin
                  state_d = REQ;
               end
            end
         end
         REQ: begin
            if (reg_ready_i) begin
               load_resp = 1'b1;
               rdata_d   = write_q ? '0 : reg_rdata_i;
               err_d     = reg_error_i;
               state_d   = RESP;
            end else begin
               if (cnt_q != CntMax) begin
                  cnt_d = cnt_q + CntWidth'(1);
               end
               if (TimeoutEn && (cnt_q == CntLast)) begin
                  load_resp = 1'b1;
                  err_d     = 1'b1;
                  timeout_d = 1'b1;
                  state_d   = RESP;
               end
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Request latches, response latches, timeout counter and timeout pulse.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q     <= '0;
         addr_q    <= '0;
         write_q   <= 1'b0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
         if (latch_req) begin
            addr_q  <= paddr_i;
            write_q <= pwrite_i;
            wdata_q <= pwdata_i;
            wstrb_q <= pwrite_i ? pstrb_i : '0;
         end
         if (load_resp) begin
            rdata_q <= rdata_d;
            err_q   <= err_d;
         end
      end
   end

   assign reg_valid_o = (state_q == REQ);
   assign reg_addr_o  = addr_q;
   assign reg_write_o = write_q;
   assign reg_wdata_o = wdata_q;
   assign reg_wstrb_o = wstrb_q;
   assign pready_o    = (state_q == RESP);
   assign pslverr_o   = pready_o & err_q;
   assign prdata_o    = pready_o ? rdata_q : '0;
   assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_apb4_to_reg_pipe.sv
// Directed bench for apb4_to_reg_pipe with TimeoutCycles=4 and PrivOnly=1.
module tb_apb4_to_reg_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        psel, penable, pwrite;
   logic [31:0] paddr;
   logic [2:0]  pprot;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [31:0] prdata;
   logic        pready, pslverr;
   logic [31:0] reg_addr;
   logic        reg_write;
   logic [31:0] reg_wdata;
   logic [3:0]  reg_wstrb;
   logic        reg_valid;
   logic [31:0] reg_rdata;
   logic        reg_error, reg_ready;
   logic        timeout;

   int checks = 0;
   int passes = 0;

   apb4_to_reg_pipe #(
      .AddrWidth(32), .DataWidth(32), .TimeoutCycles(4), .PrivOnly(1'b1)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
      .paddr_i(paddr), .pprot_i(pprot), .pwdata_i(pwdata), .pstrb_i(pstrb),
      .prdata_o(prdata), .pready_o(pready), .pslverr_o(pslverr),
      .reg_addr_o(reg_addr), .reg_write_o(reg_write), .reg_wdata_o(reg_wdata),
      .reg_wstrb_o(reg_wstrb), .reg_valid_o(reg_valid),
      .reg_rdata_i(reg_rdata), .reg_error_i(reg_error), .reg_ready_i(reg_ready),
      .timeout_o(timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One APB transfer; the endpoint raises ready after wait_n unready REQ cycles (-1: never).
   task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] strb, input logic [2:0] prot, input int wait_n,
                       input logic [31:0] rd, input logic err,
                       output int lat, output int vcnt, output int tocnt,
                       output logic [31:0] prd, output logic slv,
                       output logic [3:0] strb_seen, output logic [31:0] addr_seen,
                       output logic [31:0] wd_seen);
      int n = 0;
      lat = -1; vcnt = 0; tocnt = 0; prd = 'x; slv = 1'bx;
      strb_seen = '0; addr_seen = '0; wd_seen = '0;
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
      pstrb = strb; pprot = prot;
      while (n < 20) begin
         step();
         n++;
         penable = 1'b1;
         reg_ready = 1'b0;
         if (timeout) tocnt++;
         if (reg_valid) begin
            vcnt++;
            strb_seen = strb_seen | reg_wstrb;
            addr_seen = reg_addr;
            wd_seen   = reg_wdata;
            if (wait_n >= 0 && vcnt - 1 == wait_n) begin
               reg_ready = 1'b1; reg_rdata = rd; reg_error = err;
            end else begin
               reg_rdata = 32'hFFFF_FFFF; reg_error = 1'b1;
            end
         end
         if (pready) begin
            lat = n; prd = prdata; slv = pslverr;
            break;
         end
      end
      psel = 1'b0; penable = 1'b0; reg_ready = 1'b0; reg_error = 1'b0;
      step();
      if (timeout) tocnt++;
   endtask

   int lat, vcnt, tocnt;
   logic [31:0] prd, addr_seen, wd_seen;
   logic slv;
   logic [3:0] strb_seen;

   initial begin
      rst_n = 1'b0; psel = 0; penable = 0; pwrite = 0; paddr = '0; pprot = 3'b001;
      pwdata = '0; pstrb = '0; reg_rdata = '0; reg_error = 0; reg_ready = 0;
      step(); step();
      check("reset_outputs", {reg_valid, pready, pslverr, timeout, reg_write, reg_wstrb}, 32'h0);
      check("reset_addr_data", reg_addr | reg_wdata | prdata, 32'h0);
      rst_n = 1'b1;
      step();

      // Write, ready in the first REQ cycle; endpoint drives garbage read data
      xfer(1'b1, 32'h40, 32'hDEAD_BEEF, 4'b0011, 3'b001, 0, 32'hFFFF_FFFF, 1'b0,
           lat, vcnt, tocnt, prd, slv, strb_seen, addr_seen, wd_seen);
      check("wr_latency", 32'(lat), 32'd2);
      check("wr_valid_cycles", 32'(vcnt), 32'd1);
      check("wr_strb", 32'(strb_seen), 32'h3);
      check("wr_addr", addr_seen, 32'h40);
      check("wr_wdata", wd_seen, 32'hDEAD_BEEF);
      check("wr_slverr", 32'(slv), 32'd0);
      check("wr_prdata_zero", prd, 32'h0);

      // Read with three wait states (back-to-back with the write)
      xfer(1'b0, 32'h44, 32'h0, 4'b1111, 3'b001, 3, 32'h1234_5678, 1'b0,
           lat, vcnt, tocnt, prd, slv, strb_seen, addr_seen, wd_seen);
      check("rd_latency", 32'(lat), 32'd5);
      check("rd_prdata", prd, 32'h1234_5678);
      check("rd_strb_zero", 32'(strb_seen), 32'h0);
      check("rd_slverr", 32'(slv), 32'd0);
      check("rd_no_timeout", 32'(tocnt), 32'd0);

      // Endpoint never ready: timeout after four REQ cycles
      xfer(1'b0, 32'h48, 32'h0, 4'b0000, 3'b001, -1, 32'h0, 1'b0,
           lat, vcnt, tocnt, prd, slv, strb_seen, addr_seen, wd_seen);
      check("to_valid_cycles", 32'(vcnt), 32'd4);
      check("to_latency", 32'(lat), 32'd5);
      check("to_pulse", 32'(tocnt), 32'd1);
      check("to_slverr", 32'(slv), 32'd1);
      check("to_prdata", prd, 32'h0);

      // Ready with error on the 4th REQ cycle beats the timeout
      xfer(1'b0, 32'h4C, 32'h0, 4'b0000, 3'b001, 3, 32'hA5A5_A5A5, 1'b1,
           lat, vcnt, tocnt, prd, slv, strb_seen, addr_seen, wd_seen);
      check("race_latency", 32'(lat), 32'd5);
      check("race_slverr", 32'(slv), 32'd1);
      check("race_no_timeout", 32'(tocnt), 32'd0);
      check("race_prdata", prd, 32'hA5A5_A5A5);

      // Unprivileged write rejected without a register request
      xfer(1'b1, 32'h50, 32'h1111_2222, 4'b1111, 3'b000, 0, 32'h0, 1'b0,
           lat, vcnt, tocnt, prd, slv, strb_seen, addr_seen, wd_seen);
      check("priv_valid_cycles", 32'(vcnt), 32'd0);
      check("priv_latency", 32'(lat), 32'd1);
      check("priv_slverr", 32'(slv), 32'd1);
      xfer(1'b0, 32'h54, 32'h0, 4'b0000, 3'b001, 0, 32'hCAFE_F00D, 1'b0,
           lat, vcnt, tocnt, prd, slv, strb_seen, addr_seen, wd_seen);
      check("priv_follow_latency", 32'(lat), 32'd2);
      check("priv_follow_prdata", prd, 32'hCAFE_F00D);
      check("priv_follow_slverr", 32'(slv), 32'd0);

      // Access phase without setup phase is ignored
      psel = 1'b1; penable = 1'b1; pwrite = 1'b0; pprot = 3'b001;
      step(); step();
      check("no_setup_ignored", {30'd0, reg_valid, pready}, 32'h0);
      psel = 1'b0; penable = 1'b0;
      step();

      // Reset while in REQ
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h60; pwdata = 32'h7777_8888;
      pstrb = 4'b1111;
      step();
      penable = 1'b1;
      check("pre_reset_valid", 32'(reg_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_valid_zero", {29'd0, reg_valid, pready, timeout}, 32'h0);
      check("rst_req_zero", reg_addr | reg_wdata | 32'(reg_wstrb) | 32'(reg_write), 32'h0);
      psel = 1'b0; penable = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      xfer(1'b0, 32'h64, 32'h0, 4'b0000, 3'b001, 0, 32'h0BAD_F00D, 1'b0,
           lat, vcnt, tocnt, prd, slv, strb_seen, addr_seen, wd_seen);
      check("post_rst_latency", 32'(lat), 32'd2);
      check("post_rst_prdata", prd, 32'h0BAD_F00D);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
